// File: rtl/data_mem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and the
// request record captured at grant time.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int BYTE_LANES = 4;

    typedef struct packed {
        logic [31:0]           addr;
        logic                  we;
        logic [BYTE_LANES-1:0] be;
        logic [31:0]           wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 word array with per-byte-lane write enables and a registered read.
// Write and read are both launched by a single enable pulse.
module dmem_bank
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [BYTE_LANES-1:0] we,
    input  logic [AW-1:0]         idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH];

    // Read returns the pre-write contents; only loads use it.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (we[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the core's data-memory port: one load/store at a time with
// programmable wait states. Optional MMIO registers under DATA_MEM_MMIO_EN.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] MMIO_ADDR   = 32'h0000_F000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_req,
    output logic                  data_gnt,
    input  logic [31:0]           data_addr,
    input  logic                  data_we,
    input  logic [BYTE_LANES-1:0] data_be,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_rvalid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_err,
`ifdef DATA_MEM_MMIO_EN
    output logic [31:0]           gpio_out,
`endif
    output dmem_state_t           dbg_state
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [31:0] ARRAY_BYTES = 32'(DEPTH * 4);

    // Handshake: a request is accepted in the cycle data_req && data_gnt are
    // both high at the rising edge; exactly one data_rvalid pulse follows
    // WAIT_CYCLES+1 cycles later unless reset intervenes.

    dmem_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    dmem_req_t   req_q, cur;
    logic        in_array, hit_array, err, enter_resp;
    logic        hit_gpio, hit_cnt;
    logic [31:0] bank_rdata, mmio_rdata;

    assign dbg_state = state;

    // In IDLE the decode looks at the live inputs so a zero-wait grant can
    // commit on the same edge; afterwards it uses the latched request.
    always_comb begin
        cur = req_q;
        if (state == IDLE) begin
            cur.addr  = data_addr;
            cur.we    = data_we;
            cur.be    = data_be;
            cur.wdata = data_wdata;
        end
    end

    always_comb begin
        hit_gpio = 1'b0;
        hit_cnt  = 1'b0;
        in_array = cur.addr < ARRAY_BYTES;
`ifdef DATA_MEM_MMIO_EN
        if ((cur.addr - MMIO_ADDR) < 32'd256) begin
            in_array = 1'b0;
            hit_gpio = cur.addr == MMIO_ADDR;
            hit_cnt  = cur.addr == (MMIO_ADDR + 32'd4);
        end
`endif
        err = (cur.addr[1:0] != 2'b00) || (cur.we && cur.be == '0) ||
              !(in_array || hit_gpio || hit_cnt);
        hit_array = in_array && !err;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_gnt  = 1'b0;
        case (state)
            IDLE: begin
                if (data_req) begin
                    data_gnt = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            req_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (data_gnt) req_q <= cur;
        end
    end

    dmem_bank #(.DEPTH(DEPTH)) u_bank (
        .clk   (clk),
        .en    (enter_resp && hit_array),
        .we    (cur.we ? cur.be : '0),
        .idx   (cur.addr[AW+1:2]),
        .wdata (cur.wdata),
        .rdata (bank_rdata)
    );

`ifdef DATA_MEM_MMIO_EN
    logic [31:0] gpio_q, cycle_q, mmio_rdata_q;

    // Counter value is captured on the RESP-entry edge, like an array read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q       <= '0;
            cycle_q      <= '0;
            mmio_rdata_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (enter_resp && !err) begin
                mmio_rdata_q <= hit_cnt ? cycle_q : gpio_q;
                if (hit_gpio && cur.we) begin
                    for (int i = 0; i < BYTE_LANES; i++) begin
                        if (cur.be[i]) gpio_q[8*i +: 8] <= cur.wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign gpio_out   = gpio_q;
    assign mmio_rdata = mmio_rdata_q;
`else
    logic mmio_unused;
    assign mmio_unused = ^MMIO_ADDR;
    assign mmio_rdata  = '0;
`endif

    assign data_rvalid = (state == RESP);
    assign data_err    = (state == RESP) && err;

    always_comb begin
        data_rdata = '0;
        if (state == RESP && !err && !cur.we) begin
            data_rdata = in_array ? bank_rdata : mmio_rdata;
        end
    end

endmodule
